st_byte_packer: RTL

ST_BYTE_PACKER -- requirements
Module: st_byte_packer

---
 rtl/global_types.sv | 8 +
 rtl/st_byte_packer_if.sv | 16 +
 rtl/st_byte_packer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/global_types.sv
// Shared stream widths: byte, word and bytes-per-word.
// No logic; constants only.
// Imported by the packer, its Avalon-ST interface and the bench.
package global_types;
    localparam int B   = 8;
    localparam int W   = 32;
    localparam int BpW = W / B;
endpackage

// File: rtl/st_byte_packer_if.sv
// Avalon-ST word bundle (readyLatency 0) carried between source and sink.
// No latency; pure wiring.
// Sink throttles the source through ready.
interface avln_st;
    import global_types::*;

    logic [W-1:0]           data;
    logic                   sop;
    logic                   eop;
    logic [$clog2(BpW)-1:0] empty;
    logic                   valid;
    logic                   ready;

    modport src (output data, sop, eop, empty, valid, input ready);
    modport snk (input data, sop, eop, empty, valid, output ready);
endinterface

// File: rtl/st_byte_packer.sv
// Packs a byte stream into 32-bit Avalon-ST words, first byte in the MSB lane.
// Latency: 1 cycle from the completing byte to out.valid.
// Backpressure: one spare word in the accumulator; in_ready drops only while a word is held and out is stalled.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   byte stream sink
//   out                  Avalon-ST word source (data, sop, eop, empty, valid / ready)
//   pkt_len/pkt_len_valid byte count of each finished packet, pulsed when its eop word leaves
//                        (present only when ST_PACKER_LEN_EN is defined)
module st_byte_packer
    import global_types::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [B-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    avln_st.src              out
`ifdef ST_PACKER_LEN_EN
    ,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_len_valid
`endif
);

    localparam int EW = $clog2(BpW);
    localparam logic [EW-1:0] LAST_LANE = EW'(BpW - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // accumulator side
    state_t          r_state;
    logic [W-1:0]    r_acc;
    logic [EW-1:0]   r_idx;
    logic            r_acc_eop;
    logic [EW-1:0]   r_acc_empty;

    // output register side
    logic [W-1:0]    r_out_dat;
    logic            r_out_sop;
    logic            r_out_eop;
    logic [EW-1:0]   r_out_empty;
    logic            r_out_vld;
    logic            r_sop_pend;

    logic            w_out_free;
    logic            w_in_rdy;
    logic            w_fire;
    logic [EW-1:0]   w_wr_idx;
    logic [W-1:0]    w_word;
    logic            w_done;
    logic [EW-1:0]   w_new_empty;

    state_t          w_nxt_state;
    logic [W-1:0]    w_nxt_acc;
    logic [EW-1:0]   w_nxt_idx;
    logic            w_nxt_acc_eop;
    logic [EW-1:0]   w_nxt_acc_empty;
    logic            w_load;
    logic [W-1:0]    w_ld_dat;
    logic            w_ld_eop;
    logic [EW-1:0]   w_ld_empty;

    assign w_out_free = !r_out_vld || out.ready;
    assign w_in_rdy   = (r_state == S_FILL) || w_out_free;
    assign w_fire     = in_valid && w_in_rdy;

    // A byte accepted while a held word drains starts a fresh word at lane 0.
    assign w_wr_idx   = (r_state == S_HOLD) ? '0 : r_idx;
    assign w_done     = w_fire && ((w_wr_idx == LAST_LANE) || in_last);
    assign w_new_empty = in_last ? (LAST_LANE - w_wr_idx) : '0;

    // Starting from zero at lane 0 keeps the unused low lanes of a short word at 0.
    always_comb begin
        w_word = (w_wr_idx == '0) ? '0 : r_acc;
        for (int k = 0; k < BpW; k++) begin
            if (w_wr_idx == EW'(k)) begin
                w_word[W-1-B*k -: B] = in_data;
            end
        end
    end

    // next-state and datapath steering
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_acc       = r_acc;
        w_nxt_idx       = r_idx;
        w_nxt_acc_eop   = r_acc_eop;
        w_nxt_acc_empty = r_acc_empty;
        w_load          = 1'b0;
        w_ld_dat        = r_acc;
        w_ld_eop        = r_acc_eop;
        w_ld_empty      = r_acc_empty;

        case (r_state)
            S_FILL: begin
                if (w_fire) begin
                    w_nxt_acc = w_word;
                    w_nxt_idx = r_idx + 1'b1;
                    if (w_done) begin
                        w_nxt_idx       = '0;
                        w_nxt_acc_eop   = in_last;
                        w_nxt_acc_empty = w_new_empty;
                        if (w_out_free) begin
                            w_load     = 1'b1;
                            w_ld_dat   = w_word;
                            w_ld_eop   = in_last;
                            w_ld_empty = w_new_empty;
                        end else begin
                            w_nxt_state = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_nxt_state = S_FILL;
                    w_nxt_idx   = '0;
                    if (w_fire) begin
                        w_nxt_acc = w_word;
                        w_nxt_idx = EW'(1);
                        // A one-byte final word completes immediately and must wait its turn.
                        if (w_done) begin
                            w_nxt_idx       = '0;
                            w_nxt_acc_eop   = 1'b1;
                            w_nxt_acc_empty = w_new_empty;
                            w_nxt_state     = S_HOLD;
                        end
                    end
                end
            end
            default: begin
                w_nxt_state = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_acc       <= '0;
            r_idx       <= '0;
            r_acc_eop   <= 1'b0;
            r_acc_empty <= '0;
            r_out_dat   <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
            r_out_vld   <= 1'b0;
            r_sop_pend  <= 1'b1;
        end else begin
            r_state     <= w_nxt_state;
            r_acc       <= w_nxt_acc;
            r_idx       <= w_nxt_idx;
            r_acc_eop   <= w_nxt_acc_eop;
            r_acc_empty <= w_nxt_acc_empty;
            if (w_load) begin
                r_out_dat   <= w_ld_dat;
                r_out_sop   <= r_sop_pend;
                r_out_eop   <= w_ld_eop;
                r_out_empty <= w_ld_empty;
                r_out_vld   <= 1'b1;
                // words load in stream order, so the word after an eop opens a packet
                r_sop_pend  <= w_ld_eop;
            end else if (out.ready) begin
                r_out_vld   <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_rdy;
    assign out.data  = r_out_dat;
    assign out.sop   = r_out_sop;
    assign out.eop   = r_out_eop;
    assign out.empty = r_out_empty;
    assign out.valid = r_out_vld;

`ifdef ST_PACKER_LEN_EN
    // The length is frozen when the last byte is accepted and travels with the
    // eop word, so bytes of the next packet may arrive before it is reported.
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_acc_len;
    logic [LEN_W-1:0] r_out_len;
    logic [LEN_W-1:0] r_pkt_len;
    logic             r_pkt_len_vld;
    logic [LEN_W-1:0] w_len_inc;
    logic [LEN_W-1:0] w_nxt_acc_len;
    logic [LEN_W-1:0] w_ld_len;

    assign w_len_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_nxt_acc_len = r_acc_len;
        w_ld_len      = r_acc_len;
        if (r_state == S_FILL) begin
            w_ld_len = w_len_inc;
            if (w_done && !w_out_free) begin
                w_nxt_acc_len = w_len_inc;
            end
        end else if (w_done) begin
            w_nxt_acc_len = w_len_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_acc_len     <= '0;
            r_out_len     <= '0;
            r_pkt_len     <= '0;
            r_pkt_len_vld <= 1'b0;
        end else begin
            if (w_fire) begin
                r_cnt <= in_last ? '0 : w_len_inc;
            end
            r_acc_len <= w_nxt_acc_len;
            if (w_load) begin
                r_out_len <= w_ld_len;
            end
            r_pkt_len_vld <= r_out_vld && out.ready && r_out_eop;
            if (r_out_vld && out.ready && r_out_eop) begin
                r_pkt_len <= r_out_len;
            end
        end
    end

    assign pkt_len       = r_pkt_len;
    assign pkt_len_valid = r_pkt_len_vld;
`endif

endmodule
